cache_tag_lookup: RTL and testbench
===================================

Name: cache_tag_lookup

Overview:
- Tag stage of the set-associative cache; sits directly upstream of the cache data array.
- Holds per-way tag and valid storage and compares the request tag against every way of the indexed set.
- Produces hit, hit way and set index one cycle after the request, aligned with the data array's read data, so the hit way selects the cache line.
- Keeps per-set tree pseudo-LRU state and reports a fill victim way. Runs an invalidate sweep after reset and on flush.

Parameters:
NUM_WAYS, 4, associativity; power of two, >= 2
NUM_SETS, 16, number of sets; power of two
TAG_BITS, 20, stored tag width
NUM_WAYS_LOG, $clog2(NUM_WAYS), way index width
NUM_SETS_LOG, $clog2(NUM_SETS), set index width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
lookup_ready  out  1  stage accepting lookups/fills (low during sweep)
lookup_en  in  1  lookup request; same cycle as data-array access_en
lookup_set_idx  in  NUM_SETS_LOG  request set
lookup_tag  in  TAG_BITS  request tag
result_valid  out  1  registered: lookup accepted last cycle
result_hit  out  1  tag matched a valid way
result_hit_way_idx  out  NUM_WAYS_LOG  matching way; drives data-array way select
result_set_idx  out  NUM_SETS_LOG  registered set of the result
result_victim_way_idx  out  NUM_WAYS_LOG  way to replace on miss
fill_en  in  1  install tag
fill_way_idx  in  NUM_WAYS_LOG  way to install
fill_set_idx  in  NUM_SETS_LOG  set to install
fill_tag  in  TAG_BITS  tag to install (marked valid)
flush_en  in  1  one-cycle pulse: invalidate entire cache

Behaviour:
- Storage:
  - One sram_1r1w per way, width TAG_BITS+1 ({valid,tag}), depth NUM_SETS.
  - PLRU state is NUM_WAYS-1 bits per set, held in flops.
- Reset (rst=1):
  - All PLRU bits are cleared to 0.
  - Outputs reset as: result_valid=0, result_hit=0, result_hit_way_idx=0, result_set_idx=0, result_victim_way_idx=0, lookup_ready=0.
  - FSM enters SWEEP with counter 0.
- FSM states IDLE and SWEEP:
  - SWEEP: each cycle writes {0,0} to set counter in every way; counter+1. Leaves to IDLE after writing set NUM_SETS-1, i.e. exactly NUM_SETS cycles.
  - lookup_ready=1 only in IDLE.
  - flush_en in IDLE -> SWEEP next cycle, counter=0, PLRU cleared. flush_en during SWEEP is ignored (no restart).
  - rst mid-sweep restarts the sweep at set 0.
- Lookup, accepted when lookup_en && lookup_ready at cycle T:
  - Tags are read in T; at T+1 result_valid=1 and the result_* outputs are valid.
  - result_valid is 0 in any cycle not following an accepted lookup; other result_* then hold their last values.
  - lookup_en while not ready is dropped (no result_valid).
- Hit:
  - result_hit=1 if any way has valid && tag==lookup_tag.
  - result_hit_way_idx is the matching way; multiple matches are illegal, and the lowest index is reported.
  - On miss, result_hit_way_idx=0.
- Victim:
  - The lowest-index invalid way of the set if any; otherwise the PLRU way.
  - Computed from PLRU state as of the end of cycle T.
- Fill:
  - fill_en && lookup_ready writes {1,fill_tag} to fill_way_idx/fill_set_idx, visible to lookups from the next cycle.
  - fill_en while not ready is ignored.
- Same-cycle fill and lookup to the same set: the T+1 result reflects the fill, via forwarding of the written entry into the compare. The victim also reflects the filled way as valid.
- PLRU tree, heap-ordered, node 0 = root:
  - Bit 0 means the victim lies left (lower ways); bit 1 means right.
  - Access to way w sets every node on w's path to point away from w.
  - Hit updates occur at T+1 for result_set_idx/result_hit_way_idx. Fill updates occur in the fill cycle.
  - If both update the same set in one cycle, both apply, and the fill wins on shared nodes.
  - A miss does not update.
- No combinational path from any input to any output except the result forwarding described above, which is registered.

Test Plan:
- Reset, then hold lookup_en=1 -> lookup_ready=0 for exactly 16 cycles and no result_valid; ready=1 on cycle 17.
- After sweep, lookup set 3 tag 0x12345 -> T+1: result_valid=1, hit=0, victim=0, result_set_idx=3.
- Fill set 3 ways 0,1,2,3 with tags 0xA0..0xA3 in consecutive cycles, then lookup set 3 tag 0xA2 -> hit=1, way=2. Previous lookup of 0xA9 -> miss, victim=0.
- Set 3 fully filled as above: lookup 0xA0 (hit way 0), then lookup 0xFF -> miss, victim=2.
- Fill set 5 way 1 tag 0x77 in the same cycle as lookup set 5 tag 0x77 -> T+1 hit=1, way=1. Different set, same cycle -> no cross effect.
- After fills, pulse flush_en -> ready low 16 cycles. Then lookup 0xA0 in set 3 -> miss, victim=0. Also assert rst at sweep cycle 8 -> sweep restarts, ready low 16 more cycles.

Source files
------------

// File: rtl/cache_tag_lookup.sv
// ---------------------------------------------------------------------------
// cache_tag_lookup
//   Tag stage of a set-associative cache, sitting directly upstream of the
//   cache data array. Holds per-way {valid,tag} storage, compares a request
//   tag against every way of the indexed set, and presents hit / hit way /
//   set / victim one cycle after the request so the hit way can select the
//   line coming out of the data array. Keeps per-set tree pseudo-LRU state
//   and runs an invalidate sweep after reset and on flush.
//
// Ports
//   clk                       clock
//   rst                       synchronous reset, active-high
//   o_lookup_ready            accepting lookups/fills (low during sweep)
//   i_lookup_en               lookup request (same cycle as data-array access)
//   i_lookup_set_idx          request set
//   i_lookup_tag              request tag
//   o_result_valid            a lookup was accepted last cycle
//   o_result_hit              tag matched a valid way
//   o_result_hit_way_idx      matching way (data-array way select)
//   o_result_set_idx          set of the result
//   o_result_victim_way_idx   way to replace on a miss
//   i_fill_en                 install a tag
//   i_fill_way_idx            way to install into
//   i_fill_set_idx            set to install into
//   i_fill_tag                tag to install (marked valid)
//   i_flush_en                one-cycle pulse: invalidate the whole cache
// ---------------------------------------------------------------------------

// Simple dual-port tag RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old data.
module sram_1r1w #(
    parameter int WIDTH  = 21,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // NOTE: the array has no reset; the invalidate sweep clears valid bits,
    // which keeps this mappable onto a real RAM macro.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

module cache_tag_lookup #(
    parameter int NUM_WAYS     = 4,
    parameter int NUM_SETS     = 16,
    parameter int TAG_BITS     = 20,
    parameter int NUM_WAYS_LOG = $clog2(NUM_WAYS),
    parameter int NUM_SETS_LOG = $clog2(NUM_SETS)
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    o_lookup_ready,
    input  logic                    i_lookup_en,
    input  logic [NUM_SETS_LOG-1:0] i_lookup_set_idx,
    input  logic [TAG_BITS-1:0]     i_lookup_tag,
    output logic                    o_result_valid,
    output logic                    o_result_hit,
    output logic [NUM_WAYS_LOG-1:0] o_result_hit_way_idx,
    output logic [NUM_SETS_LOG-1:0] o_result_set_idx,
    output logic [NUM_WAYS_LOG-1:0] o_result_victim_way_idx,
    input  logic                    i_fill_en,
    input  logic [NUM_WAYS_LOG-1:0] i_fill_way_idx,
    input  logic [NUM_SETS_LOG-1:0] i_fill_set_idx,
    input  logic [TAG_BITS-1:0]     i_fill_tag,
    input  logic                    i_flush_en
);

    localparam int ENTRY_W = TAG_BITS + 1;   // {valid, tag}
    localparam int PLRU_W  = NUM_WAYS - 1;   // tree nodes per set

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_t;

    // -----------------------------------------------------------------------
    // Tree PLRU helpers. Node 0 is the root, children of n are 2n+1 / 2n+2.
    // A node bit of 0 points the victim left (lower ways), 1 points right.
    // -----------------------------------------------------------------------
    function automatic logic [PLRU_W-1:0] plru_touch(
        input logic [PLRU_W-1:0]       bits,
        input logic [NUM_WAYS_LOG-1:0] way
    );
        logic [PLRU_W-1:0]       v_bits;
        logic [NUM_WAYS_LOG-1:0] v_node;
        logic [NUM_WAYS_LOG-1:0] v_way;
        logic                    v_dir;
        v_bits = bits;
        v_node = '0;
        v_way  = way;
        for (int lvl = 0; lvl < NUM_WAYS_LOG; lvl++) begin
            v_dir         = v_way[NUM_WAYS_LOG-1];
            v_way         = v_way << 1;
            v_bits[v_node] = ~v_dir;   // point away from the accessed way
            v_node        = NUM_WAYS_LOG'(2 * int'(v_node) + 1 + int'(v_dir));
        end
        return v_bits;
    endfunction

    function automatic logic [NUM_WAYS_LOG-1:0] plru_victim(
        input logic [PLRU_W-1:0] bits
    );
        logic [NUM_WAYS_LOG-1:0] v_node;
        logic [NUM_WAYS_LOG-1:0] v_way;
        logic                    v_dir;
        v_node = '0;
        v_way  = '0;
        for (int lvl = 0; lvl < NUM_WAYS_LOG; lvl++) begin
            v_dir  = bits[v_node];
            v_way  = NUM_WAYS_LOG'({v_way, v_dir});
            v_node = NUM_WAYS_LOG'(2 * int'(v_node) + 1 + int'(v_dir));
        end
        return v_way;
    endfunction

    // -----------------------------------------------------------------------
    // Sweep FSM: invalidates one set per cycle across all ways.
    // -----------------------------------------------------------------------
    state_t                  r_state;
    logic [NUM_SETS_LOG-1:0] r_sweep_cnt;
    logic                    r_ready;

    logic w_sweep;
    logic w_lookup_acc;
    logic w_fill_acc;
    logic w_flush_acc;

    assign w_sweep      = (r_state == ST_SWEEP);
    assign w_lookup_acc = i_lookup_en & r_ready;
    assign w_fill_acc   = i_fill_en & r_ready;
    assign w_flush_acc  = i_flush_en & r_ready;

    // NOTE: sequential state is always assigned with <= so every flop sees
    // the pre-edge value of every other flop, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SWEEP;
            r_sweep_cnt <= '0;
            r_ready     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_flush_en) begin
                        r_state     <= ST_SWEEP;
                        r_sweep_cnt <= '0;
                        r_ready     <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    r_sweep_cnt <= r_sweep_cnt + 1'b1;
                    if (r_sweep_cnt == NUM_SETS_LOG'(NUM_SETS - 1)) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_SWEEP;
                end
            endcase
        end
    end

    assign o_lookup_ready = r_ready;

    // -----------------------------------------------------------------------
    // Per-way tag RAMs. The sweep owns the write port while it runs.
    // -----------------------------------------------------------------------
    logic [ENTRY_W-1:0] w_rd_entry [NUM_WAYS];
    logic [ENTRY_W-1:0] w_entry    [NUM_WAYS];

    // Registered request, plus the fill that landed on the same set in the
    // same cycle (the RAM returns old data for that, so it is forwarded).
    logic                    r_valid;
    logic [NUM_SETS_LOG-1:0] r_req_set;
    logic [TAG_BITS-1:0]     r_req_tag;
    logic                    r_fwd_en;
    logic [NUM_WAYS_LOG-1:0] r_fwd_way;
    logic [TAG_BITS-1:0]     r_fwd_tag;

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        logic w_wr_en;
        assign w_wr_en = w_sweep |
                         (w_fill_acc & (i_fill_way_idx == NUM_WAYS_LOG'(g)));

        sram_1r1w #(
            .WIDTH  (ENTRY_W),
            .DEPTH  (NUM_SETS),
            .ADDR_W (NUM_SETS_LOG)
        ) u_tag_ram (
            .clk       (clk),
            .i_rd_en   (w_lookup_acc),
            .i_rd_addr (i_lookup_set_idx),
            .o_rd_data (w_rd_entry[g]),
            .i_wr_en   (w_wr_en),
            .i_wr_addr (w_sweep ? r_sweep_cnt : i_fill_set_idx),
            .i_wr_data (w_sweep ? {ENTRY_W{1'b0}} : {1'b1, i_fill_tag})
        );

        assign w_entry[g] = (r_fwd_en && (r_fwd_way == NUM_WAYS_LOG'(g)))
                          ? {1'b1, r_fwd_tag} : w_rd_entry[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_req_set <= '0;
            r_req_tag <= '0;
            r_fwd_en  <= 1'b0;
            r_fwd_way <= '0;
            r_fwd_tag <= '0;
        end else begin
            r_valid <= w_lookup_acc;
            if (w_lookup_acc) begin
                r_req_set <= i_lookup_set_idx;
                r_req_tag <= i_lookup_tag;
                r_fwd_en  <= w_fill_acc && (i_fill_set_idx == i_lookup_set_idx);
                r_fwd_way <= i_fill_way_idx;
                r_fwd_tag <= i_fill_tag;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Compare and victim selection (cycle T+1).
    // -----------------------------------------------------------------------
    logic [PLRU_W-1:0]       r_plru     [NUM_SETS];
    logic [PLRU_W-1:0]       w_plru_next[NUM_SETS];
    logic                    w_hit;
    logic [NUM_WAYS_LOG-1:0] w_hit_way;
    logic                    w_any_invalid;
    logic [NUM_WAYS_LOG-1:0] w_first_invalid;
    logic [NUM_WAYS_LOG-1:0] w_victim;

    // NOTE: every always_comb output gets a default before any condition so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_hit           = 1'b0;
        w_hit_way       = '0;
        w_any_invalid   = 1'b0;
        w_first_invalid = '0;
        // Scan high to low so the lowest-index way wins.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (w_entry[w][TAG_BITS] && (w_entry[w][TAG_BITS-1:0] == r_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = NUM_WAYS_LOG'(w);
            end
            if (!w_entry[w][TAG_BITS]) begin
                w_any_invalid   = 1'b1;
                w_first_invalid = NUM_WAYS_LOG'(w);
            end
        end
        w_victim = w_any_invalid ? w_first_invalid : plru_victim(r_plru[r_req_set]);
    end

    // Hit update for the presented result first, then the fill on top so
    // the fill wins on shared nodes when both touch the same set.
    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            w_plru_next[s] = r_plru[s];
            if (r_valid && w_hit && (r_req_set == NUM_SETS_LOG'(s))) begin
                w_plru_next[s] = plru_touch(w_plru_next[s], w_hit_way);
            end
            if (w_fill_acc && (i_fill_set_idx == NUM_SETS_LOG'(s))) begin
                w_plru_next[s] = plru_touch(w_plru_next[s], i_fill_way_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SETS; s++) begin
            if (rst || w_sweep || w_flush_acc) begin
                r_plru[s] <= '0;
            end else begin
                r_plru[s] <= w_plru_next[s];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Result outputs: live in the result cycle, held otherwise.
    // -----------------------------------------------------------------------
    logic                    r_hold_hit;
    logic [NUM_WAYS_LOG-1:0] r_hold_way;
    logic [NUM_WAYS_LOG-1:0] r_hold_victim;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_hit    <= 1'b0;
            r_hold_way    <= '0;
            r_hold_victim <= '0;
        end else if (r_valid) begin
            r_hold_hit    <= w_hit;
            r_hold_way    <= w_hit_way;
            r_hold_victim <= w_victim;
        end
    end

    assign o_result_valid          = r_valid;
    assign o_result_hit            = r_valid ? w_hit     : r_hold_hit;
    assign o_result_hit_way_idx    = r_valid ? w_hit_way : r_hold_way;
    assign o_result_victim_way_idx = r_valid ? w_victim  : r_hold_victim;
    assign o_result_set_idx        = r_req_set;

endmodule

// File: tb/tb_cache_tag_lookup.sv
// ---------------------------------------------------------------------------
// Testbench for cache_tag_lookup (4 ways, 16 sets, 20-bit tags).
// Stimulus pushes the hand-computed expected result of every accepted lookup
// into a queue; a monitor on the falling edge pops and compares whenever
// o_result_valid is high.
// ---------------------------------------------------------------------------
module tb_cache_tag_lookup;

    typedef struct {
        logic       hit;
        logic [1:0] way;
        logic [3:0] set;
        logic [1:0] victim;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        lookup_ready;
    logic        lookup_en;
    logic [3:0]  lookup_set_idx;
    logic [19:0] lookup_tag;
    logic        result_valid;
    logic        result_hit;
    logic [1:0]  result_hit_way_idx;
    logic [3:0]  result_set_idx;
    logic [1:0]  result_victim_way_idx;
    logic        fill_en;
    logic [1:0]  fill_way_idx;
    logic [3:0]  fill_set_idx;
    logic [19:0] fill_tag;
    logic        flush_en;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_res = 0;
    exp_t exp_q[$];

    cache_tag_lookup dut (
        .clk                     (clk),
        .rst                     (rst),
        .o_lookup_ready          (lookup_ready),
        .i_lookup_en             (lookup_en),
        .i_lookup_set_idx        (lookup_set_idx),
        .i_lookup_tag            (lookup_tag),
        .o_result_valid          (result_valid),
        .o_result_hit            (result_hit),
        .o_result_hit_way_idx    (result_hit_way_idx),
        .o_result_set_idx        (result_set_idx),
        .o_result_victim_way_idx (result_victim_way_idx),
        .i_fill_en               (fill_en),
        .i_fill_way_idx          (fill_way_idx),
        .i_fill_set_idx          (fill_set_idx),
        .i_fill_tag              (fill_tag),
        .i_flush_en              (flush_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check($sformatf("unexpected result_valid #%0d", n_res), 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("res%0d hit", n_res),    result_hit,            e.hit);
                check($sformatf("res%0d way", n_res),    result_hit_way_idx,    e.way);
                check($sformatf("res%0d set", n_res),    result_set_idx,        e.set);
                check($sformatf("res%0d victim", n_res), result_victim_way_idx, e.victim);
            end
            n_res++;
        end
    end

    // Inputs are set just after a rising edge and sampled at the next one.
    task automatic tick();
        @(posedge clk);
        #1;
        lookup_en = 1'b0;
        fill_en   = 1'b0;
        flush_en  = 1'b0;
    endtask

    task automatic do_lookup(input logic [3:0] set, input logic [19:0] tag,
                             input logic hit, input logic [1:0] way, input logic [1:0] victim);
        exp_t e;
        check($sformatf("ready before lookup set%0d tag%0h", set, tag), lookup_ready, 1);
        lookup_en      = 1'b1;
        lookup_set_idx = set;
        lookup_tag     = tag;
        e.hit = hit; e.way = way; e.set = set; e.victim = victim;
        exp_q.push_back(e);
    endtask

    task automatic do_fill(input logic [3:0] set, input logic [1:0] way, input logic [19:0] tag);
        fill_en      = 1'b1;
        fill_set_idx = set;
        fill_way_idx = way;
        fill_tag     = tag;
    endtask

    // Starts in sweep cycle 1. Checks ready low (and no results) each sweep
    // cycle, attempts a fill to set 5 in cycle 12 (must be ignored), and
    // optionally pulses flush or rst. Without rst, checks ready in cycle 17.
    task automatic wait_sweep(input string name, input int flush_at, input int rst_at);
        int n;
        n = (rst_at > 0) ? rst_at : 16;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            check($sformatf("%s ready c%0d", name, i), lookup_ready, 0);
            check($sformatf("%s valid c%0d", name, i), result_valid, 0);
            flush_en     = (i == flush_at);
            rst          = (i == rst_at);
            fill_en      = (i == 12);
            fill_set_idx = 4'd5;
            fill_way_idx = 2'd0;
            fill_tag     = 20'h00033;
            @(posedge clk);
        end
        #1;
        flush_en = 1'b0;
        fill_en  = 1'b0;
        rst      = 1'b0;
        if (rst_at <= 0) begin
            @(negedge clk);
            check($sformatf("%s ready c17", name), lookup_ready, 1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst            = 1'b1;
        lookup_en      = 1'b1;
        lookup_set_idx = 4'd3;
        lookup_tag     = 20'h12345;
        fill_en        = 1'b0;
        fill_way_idx   = '0;
        fill_set_idx   = '0;
        fill_tag       = '0;
        flush_en       = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready",  lookup_ready,          0);
        check("reset valid",  result_valid,          0);
        check("reset hit",    result_hit,            0);
        check("reset way",    result_hit_way_idx,    0);
        check("reset set",    result_set_idx,        0);
        check("reset victim", result_victim_way_idx, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // lookup_en held through the sweep; accepted only in cycle 17.
        e.hit = 1'b0; e.way = 2'd0; e.set = 4'd3; e.victim = 2'd0;
        exp_q.push_back(e);
        wait_sweep("reset", 0, 0);
        lookup_en = 1'b0;

        // Miss on empty set, then fill all four ways of set 3.
        do_lookup(4'd3, 20'h000A9, 1'b0, 2'd0, 2'd0); tick();
        do_fill(4'd3, 2'd0, 20'h000A0); tick();
        do_fill(4'd3, 2'd1, 20'h000A1); tick();
        do_fill(4'd3, 2'd2, 20'h000A2); tick();
        do_fill(4'd3, 2'd3, 20'h000A3); tick();

        // PLRU after fills: root0 n1=0 n2=0.
        do_lookup(4'd3, 20'h000A0, 1'b1, 2'd0, 2'd0); tick(); // -> root1 n1=1
        do_lookup(4'd3, 20'h000FF, 1'b0, 2'd0, 2'd2); tick();
        do_lookup(4'd3, 20'h000A2, 1'b1, 2'd2, 2'd2); tick(); // -> root0 n2=1
        do_lookup(4'd3, 20'h000FF, 1'b0, 2'd0, 2'd1); tick();
        do_lookup(4'd3, 20'h000A3, 1'b1, 2'd3, 2'd1); tick();
        // Hit on way 3 and fill of way 0 update set 3 together; fill wins
        // on the root: root1 n1=1 n2=0 -> victim 2.
        do_fill(4'd3, 2'd0, 20'h000A0);
        do_lookup(4'd3, 20'h000FF, 1'b0, 2'd0, 2'd2); tick();

        // Same-cycle fill and lookup, same set: forwarded hit.
        do_fill(4'd5, 2'd1, 20'h00077);
        do_lookup(4'd5, 20'h00077, 1'b1, 2'd1, 2'd0); tick();
        // Same-cycle fill makes way 0 valid for the victim choice.
        do_fill(4'd6, 2'd0, 20'h00010);
        do_lookup(4'd6, 20'h00099, 1'b0, 2'd0, 2'd1); tick();
        // Different sets in the same cycle: no cross effect.
        do_fill(4'd7, 2'd2, 20'h00055);
        do_lookup(4'd8, 20'h00055, 1'b0, 2'd0, 2'd0); tick();
        do_lookup(4'd7, 20'h00055, 1'b1, 2'd2, 2'd0); tick();

        // Result outputs hold when result_valid drops.
        tick();
        @(negedge clk);
        check("hold valid", result_valid,       0);
        check("hold hit",   result_hit,         1);
        check("hold way",   result_hit_way_idx, 2);
        check("hold set",   result_set_idx,     7);
        @(posedge clk);
        #1;

        // Flush; a second flush in sweep cycle 5 must not restart it.
        flush_en = 1'b1; tick();
        wait_sweep("flush", 5, 0);
        do_lookup(4'd5, 20'h00033, 1'b0, 2'd0, 2'd0); tick();
        do_lookup(4'd3, 20'h000A0, 1'b0, 2'd0, 2'd0); tick();

        // Flush again, reset at sweep cycle 8 restarts the sweep.
        flush_en = 1'b1; tick();
        wait_sweep("flush2", 0, 8);
        wait_sweep("rst_restart", 0, 0);
        do_lookup(4'd3, 20'h000A2, 1'b0, 2'd0, 2'd0); tick();
        do_fill(4'd4, 2'd3, 20'hABCDE); tick();
        do_lookup(4'd4, 20'hABCDE, 1'b1, 2'd3, 2'd0); tick();

        repeat (3) tick();
        check("scoreboard drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
